pixel_plot_arbiter: RTL and testbench

//   Sits between the snake datapath / food logic and vga_adapter; owns the VGA x/y/colour/plot inputs.

---
 rtl/pixel_plot_arbiter_pkg.sv | 37 +++
 rtl/pixel_plot_arbiter_plot_fifo.sv | 66 ++++++
 rtl/pixel_plot_arbiter.sv | 136 +++++++++++++
 tb/tb_pixel_plot_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_plot_arbiter_pkg.sv
// Shared screen geometry, colour codes, FSM encoding and pixel-entry layout
// for the pixel plot arbiter and its FIFO.
package pixel_plot_arbiter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;

    localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COL_W-1:0] COL_WHITE = 3'b111;
    localparam logic [COL_W-1:0] COL_RED   = 3'b100;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pix_t;

    localparam int PIX_W = $bits(pix_t);

    function automatic logic pix_in_range(
        input logic [X_W-1:0] px,
        input logic [Y_W-1:0] py,
        input int             x_max,
        input int             y_max
    );
        return (int'(px) <= x_max) && (int'(py) <= y_max);
    endfunction

endpackage

// File: rtl/pixel_plot_arbiter_plot_fifo.sv
// Single-clock FIFO for pending pixel writes; flush empties it in one edge.
// Push while full and pop while empty are ignored.
module plot_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_plot_arbiter.sv
// Owns the VGA plot port: food-over-snake arbitration into a FIFO, one plot per clk.
// S_CLEAR | sweeping CLEAR_COLOUR over the whole screen   S_RUN | draining queued pixel writes
module pixel_plot_arbiter
    import pixel_plot_arbiter_pkg::*;
#(
    parameter int               FIFO_DEPTH   = 8,
    parameter int               X_MAX        = SCREEN_W - 1,
    parameter int               Y_MAX        = SCREEN_H - 1,
    parameter logic [COL_W-1:0] CLEAR_COLOUR = COL_BLACK
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_req,
    input  logic             snake_valid,
    input  logic [X_W-1:0]   snake_x,
    input  logic [Y_W-1:0]   snake_y,
    input  logic [COL_W-1:0] snake_colour,
    output logic             snake_ready,
    input  logic             food_valid,
    input  logic [X_W-1:0]   food_x,
    input  logic [Y_W-1:0]   food_y,
    input  logic [COL_W-1:0] food_colour,
    output logic             food_ready,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [X_W-1:0] X_LAST = X_MAX[X_W-1:0];
    localparam logic [Y_W-1:0] Y_LAST = Y_MAX[Y_W-1:0];

    state_t           r_state;
    logic [X_W-1:0]   r_sx;
    logic [Y_W-1:0]   r_sy;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [COL_W-1:0] r_colour;
    logic             r_plot;

    pix_t             w_sel;
    pix_t             w_head;
    logic             w_run_open;
    logic             w_handshake;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;

    // clear_req blocks acceptance in its own cycle so nothing slips past the flush
    assign w_run_open  = (r_state == S_RUN) && !w_full && !clear_req;
    assign food_ready  = w_run_open && food_valid;
    assign snake_ready = w_run_open && !food_valid;

    assign w_sel = food_valid ? pix_t'({food_x, food_y, food_colour})
                              : pix_t'({snake_x, snake_y, snake_colour});
    assign w_handshake = (food_valid && food_ready) || (snake_valid && snake_ready);
    assign w_push      = w_handshake && pix_in_range(w_sel.x, w_sel.y, X_MAX, Y_MAX);
    assign w_pop       = (r_state == S_RUN) && !w_empty && !clear_req;

    plot_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_plot_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .flush (clear_req),
        .push  (w_push),
        .din   (w_sel),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_CLEAR;
            r_sx     <= '0;
            r_sy     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else if (clear_req) begin
            r_state  <= S_CLEAR;
            r_sx     <= '0;
            r_sy     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= CLEAR_COLOUR;
            r_plot   <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_x      <= r_sx;
                    r_y      <= r_sy;
                    r_colour <= CLEAR_COLOUR;
                    r_plot   <= 1'b1;
                    if (r_sx == X_LAST) begin
                        r_sx <= '0;
                        if (r_sy == Y_LAST) begin
                            r_sy    <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_sy <= r_sy + 1'b1;
                        end
                    end else begin
                        r_sx <= r_sx + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_pop) begin
                        r_x      <= w_head.x;
                        r_y      <= w_head.y;
                        r_colour <= w_head.colour;
                        r_plot   <= 1'b1;
                    end else begin
                        r_plot   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = (r_state == S_CLEAR) || (w_count != '0);

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Scoreboard bench: the driver queues expected plots with their due cycle, the monitor
// pops and compares every plot; a reference model of sweep, priority and range rules.
module tb_pixel_plot_arbiter;
    import pixel_plot_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear_req = 1'b0;
    logic       snake_valid = 1'b0, food_valid = 1'b0;
    logic [7:0] snake_x = '0, food_x = '0;
    logic [6:0] snake_y = '0, food_y = '0;
    logic [2:0] snake_colour = '0, food_colour = '0;
    logic       snake_ready, food_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy;

    logic        f_flush = 1'b0, f_push = 1'b0, f_pop = 1'b0;
    logic [17:0] f_din = '0;
    logic [17:0] f_dout;
    logic        f_full, f_empty;
    logic [1:0]  f_count;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_push = 1'b0;

    pixel_plot_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_req    (clear_req),
        .snake_valid  (snake_valid),
        .snake_x      (snake_x),
        .snake_y      (snake_y),
        .snake_colour (snake_colour),
        .snake_ready  (snake_ready),
        .food_valid   (food_valid),
        .food_x       (food_x),
        .food_y       (food_y),
        .food_colour  (food_colour),
        .food_ready   (food_ready),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy)
    );

    plot_fifo #(.WIDTH(18), .DEPTH(2)) u_fifo2 (
        .clk   (clk),
        .rst_n (reset_n),
        .flush (f_flush),
        .push  (f_push),
        .din   (f_din),
        .pop   (f_pop),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL global_timeout: got cycle %0d, required finish earlier", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every plot must match the oldest expectation, at its due cycle
    always @(negedge clk) begin
        if (reset_n && plot) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot: got (%0d,%0d,%0h) at cycle %0d, expected no plot",
                         x, y, colour, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (x !== e.x || y !== e.y || colour !== e.c || cyc != e.t) begin
                    errors++;
                    $display("FAIL plot_stream: got (%0d,%0d,%0h)@%0d expected (%0d,%0d,%0h)@%0d",
                             x, y, colour, cyc, e.x, e.y, e.c, e.t);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_exp(input int px, input int py, input int pc, input int t);
        exp_t e;
        e.x = 8'(px);
        e.y = 7'(py);
        e.c = 3'(pc);
        e.t = t;
        q.push_back(e);
    endtask

    task automatic push_sweep(input int t0);
        for (int yy = 0; yy < SCREEN_H; yy++)
            for (int xx = 0; xx < SCREEN_W; xx++)
                push_exp(xx, yy, 0, t0 + yy * SCREEN_W + xx);
    endtask

    task automatic wait_drain(input int budget, input bit chk_rdy);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            if (chk_rdy && (n % 97 == 0) && q.size() > 1) begin
                chk("sweep_food_ready", 32'(food_ready), 32'(0));
                chk("sweep_snake_ready", 32'(snake_ready), 32'(0));
            end
            tick();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending plots, expected 0", q.size());
            q.delete();
        end
        food_valid = 1'b0;
        snake_valid = 1'b0;
        tick();
        chk("idle_plot", 32'(plot), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        prev_push = 1'b0;
    endtask

    // one S_RUN cycle: model says food wins, snake gets ready only when food is idle
    task automatic run_cycle(input logic fv, input int fx, input int fy, input int fc,
                             input logic sv, input int sx, input int sy, input int sc);
        int  ax, ay, ac;
        logic acc;
        food_valid = fv;  food_x = 8'(fx);  food_y = 7'(fy);  food_colour = 3'(fc);
        snake_valid = sv; snake_x = 8'(sx); snake_y = 7'(sy); snake_colour = 3'(sc);
        #1;
        chk("food_ready", 32'(food_ready), 32'(fv));
        chk("snake_ready", 32'(snake_ready), 32'(!fv));
        chk("run_busy", 32'(busy), 32'(prev_push));
        acc = fv | sv;
        ax = fv ? fx : sx;
        ay = fv ? fy : sy;
        ac = fv ? fc : sc;
        prev_push = acc && ax < SCREEN_W && ay < SCREEN_H;
        if (prev_push) push_exp(ax, ay, ac, cyc + 2);
        tick();
    endtask

    task automatic idle_cycle();
        food_valid = 1'b0;
        snake_valid = 1'b0;
        #1;
        chk("idle_cycle_busy", 32'(busy), 32'(prev_push));
        prev_push = 1'b0;
        tick();
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(1'($urandom), $urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 7),
                      1'($urandom), $urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 7));
        idle_cycle();
        idle_cycle();
    endtask

    task automatic issue_clear();
        clear_req = 1'b1;
        food_valid = 1'b1;
        snake_valid = 1'b1;
        #1;
        chk("clear_food_ready", 32'(food_ready), 32'(0));
        chk("clear_snake_ready", 32'(snake_ready), 32'(0));
        q.delete();
        push_exp(0, 0, 0, cyc + 1);
        push_sweep(cyc + 2);
        prev_push = 1'b0;
        tick();
        clear_req = 1'b0;
        chk("clear_busy", 32'(busy), 32'(1));
    endtask

    initial begin
        int n;
        food_valid = 1'b1;  food_x = 8'd3; food_y = 7'd4;
        snake_valid = 1'b1; snake_x = 8'd5; snake_y = 7'd6;
        tick();
        tick();
        chk("rst_plot", 32'(plot), 32'(0));
        chk("rst_x", 32'(x), 32'(0));
        chk("rst_y", 32'(y), 32'(0));
        chk("rst_colour", 32'(colour), 32'(0));
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_food_ready", 32'(food_ready), 32'(0));
        chk("rst_snake_ready", 32'(snake_ready), 32'(0));

        reset_n = 1'b1;
        push_sweep(cyc + 1);
        wait_drain(19300, 1'b1);

        // priority: both offered, food first, then snake
        run_cycle(1'b1, 10, 20, 3'b100, 1'b1, 11, 20, 3'b111);
        run_cycle(1'b0, 0, 0, 0, 1'b1, 11, 20, 3'b111);
        idle_cycle();
        idle_cycle();

        for (int i = 0; i < 20; i++)
            run_cycle(1'b0, 0, 0, 0, 1'b1, i * 7, i + 3, i);
        idle_cycle();
        idle_cycle();

        run_cycle(1'b0, 0, 0, 0, 1'b1, 160, 5, 7);
        run_cycle(1'b0, 0, 0, 0, 1'b1, 5, 120, 7);
        run_cycle(1'b0, 0, 0, 0, 1'b1, 5, 5, 7);
        idle_cycle();
        idle_cycle();
        chk("hold_x", 32'(x), 32'(5));
        chk("hold_y", 32'(y), 32'(5));
        chk("hold_colour", 32'(colour), 32'(7));

        random_run(300);

        run_cycle(1'b0, 0, 0, 0, 1'b1, 30, 30, 1);
        run_cycle(1'b1, 31, 30, 2, 1'b0, 0, 0, 0);
        run_cycle(1'b0, 0, 0, 0, 1'b1, 32, 30, 3);
        issue_clear();

        n = 0;
        while (!(plot && x == 8'd40 && y == 7'd3) && n < 1000) begin
            tick();
            n++;
        end
        chk("reach_40_3", 32'(plot && x == 8'd40 && y == 7'd3), 32'(1));
        issue_clear();
        repeat (300) tick();

        reset_n = 1'b0;
        #1;
        chk("midrst_plot", 32'(plot), 32'(0));
        chk("midrst_x", 32'(x), 32'(0));
        chk("midrst_y", 32'(y), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(1));
        chk("midrst_snake_ready", 32'(snake_ready), 32'(0));
        q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        push_sweep(cyc + 1);
        wait_drain(19300, 1'b1);

        random_run(100);

        // standalone depth-2 FIFO: full at count 2, push ignored while full, order kept
        f_push = 1'b1; f_din = 18'h01234;
        tick();
        f_din = 18'h02abc;
        tick();
        chk("fifo_full", 32'(f_full), 32'(1));
        chk("fifo_count2", 32'(f_count), 32'(2));
        f_din = 18'h03fff;
        tick();
        chk("fifo_count_held", 32'(f_count), 32'(2));
        f_push = 1'b0; f_pop = 1'b1;
        #1;
        chk("fifo_head0", 32'(f_dout), 32'(18'h01234));
        tick();
        chk("fifo_head1", 32'(f_dout), 32'(18'h02abc));
        tick();
        f_pop = 1'b0;
        chk("fifo_empty", 32'(f_empty), 32'(1));
        chk("fifo_count0", 32'(f_count), 32'(0));
        f_push = 1'b1; f_din = 18'h00055;
        tick();
        f_push = 1'b0; f_flush = 1'b1;
        tick();
        f_flush = 1'b0;
        chk("fifo_flush", 32'(f_empty), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
